// File: rtl/mem_dbus_stage_pkg.sv
// Shared types and helpers for the memory-stage controller: address/data
// widths, access sizes, the instruction opcode set, the controller state
// encoding and small decode functions used by the datapath helpers.
package mem_dbus_stage_pkg;

   typedef logic [63:0] addr_t;
   typedef logic [63:0] word_t;
   typedef logic [7:0]  strobe_t;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef enum logic [4:0] {
      OP_NONE   = 5'd0,
      OP_ALU    = 5'd1,
      OP_BRANCH = 5'd2,
      LB        = 5'd3,
      LH        = 5'd4,
      LW        = 5'd5,
      LD        = 5'd6,
      LBU       = 5'd7,
      LHU       = 5'd8,
      LWU       = 5'd9,
      SB        = 5'd10,
      SH        = 5'd11,
      SW        = 5'd12,
      SD        = 5'd13
   } instruction_type;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      HOLD = 2'd2
   } mem_state_t;

   function automatic logic is_store(input instruction_type op);
      logic r;
      case (op)
         SB, SH, SW, SD: r = 1'b1;
         default:        r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_mem_op(input instruction_type op);
      logic r;
      case (op)
         LB, LH, LW, LD, LBU, LHU, LWU: r = 1'b1;
         SB, SH, SW, SD:                r = 1'b1;
         default:                       r = 1'b0;
      endcase
      return r;
   endfunction

   // Non-memory ops report the byte size; they never reach the bus.
   function automatic msize_t op_size(input instruction_type op);
      msize_t r;
      case (op)
         LB, LBU, SB: r = MSIZE1;
         LH, LHU, SH: r = MSIZE2;
         LW, LWU, SW: r = MSIZE4;
         LD, SD:      r = MSIZE8;
         default:     r = MSIZE1;
      endcase
      return r;
   endfunction

   function automatic strobe_t size_mask(input msize_t size);
      strobe_t r;
      case (size)
         MSIZE1:  r = 8'h01;
         MSIZE2:  r = 8'h03;
         MSIZE4:  r = 8'h0F;
         MSIZE8:  r = 8'hFF;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic misaligned(input addr_t addr, input msize_t size);
      logic r;
      case (size)
         MSIZE1:  r = 1'b0;
         MSIZE2:  r = (addr[0] != 1'b0);
         MSIZE4:  r = (addr[1:0] != 2'b00);
         MSIZE8:  r = (addr[2:0] != 3'b000);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_dbus_stage_align.sv
// Data-bus lane helpers for the memory stage:
//   databus_pre_align   - builds size, byte strobes and lane-shifted store data
//   databus_post_align  - extracts and extends the loaded value from the bus word
//   mem_misalign_check  - flags memory ops whose address is not size-aligned
// Byte strobes that would land beyond lane 7 are simply dropped; a misaligned
// access is never split into two bus transfers.
module databus_pre_align
   import mem_dbus_stage_pkg::*;
(
   input  instruction_type op,
   input  addr_t           addr,
   input  word_t           wdata,
   output addr_t           req_addr,
   output msize_t          req_size,
   output strobe_t         req_strobe,
   output word_t           req_data
);

   logic [5:0] shift_s;

   assign shift_s = {addr[2:0], 3'b000};

   // Size from the opcode; strobes and shifted data only for stores.
   always_comb begin
      req_addr   = addr;
      req_size   = op_size(op);
      req_strobe = 8'h00;
      req_data   = 64'd0;
      if (is_store(op)) begin
         req_strobe = size_mask(op_size(op)) << addr[2:0];
         req_data   = wdata << shift_s;
      end else begin
         req_strobe = 8'h00;
         req_data   = 64'd0;
      end
   end

endmodule

module databus_post_align
   import mem_dbus_stage_pkg::*;
(
   input  instruction_type op,
   input  logic [2:0]      offset,
   input  word_t           rdata,
   output word_t           result
);

   word_t shifted_s;

   assign shifted_s = rdata >> {offset, 3'b000};

   // Sign or zero extend the addressed lanes; stores and other ops yield 0.
   always_comb begin
      result = 64'd0;
      case (op)
         LB:      result = {{56{shifted_s[7]}}, shifted_s[7:0]};
         LBU:     result = {56'd0, shifted_s[7:0]};
         LH:      result = {{48{shifted_s[15]}}, shifted_s[15:0]};
         LHU:     result = {48'd0, shifted_s[15:0]};
         LW:      result = {{32{shifted_s[31]}}, shifted_s[31:0]};
         LWU:     result = {32'd0, shifted_s[31:0]};
         LD:      result = shifted_s;
         default: result = 64'd0;
      endcase
   end

endmodule

module mem_misalign_check
   import mem_dbus_stage_pkg::*;
(
   input  instruction_type op,
   input  addr_t           addr,
   output logic            trap
);

   assign trap = is_mem_op(op) && misaligned(addr, op_size(op));

endmodule

// File: rtl/mem_dbus_stage.sv
// Memory-stage controller: accepts one load/store per transaction, drives the
// data-bus request until data_ok, then holds the extended result until
// writeback takes it. Non-memory ops pass their value straight to the result.
// Optional feature: define MEM_MISALIGN_TRAP_EN to turn size-misaligned memory
// ops into an immediate exception result (out_exc=1) with no bus request.
module mem_dbus_stage
   import mem_dbus_stage_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  instruction_type in_op,
   input  addr_t           in_addr,
   input  word_t           in_wdata,
   output logic            dreq_valid,
   output addr_t           dreq_addr,
   output msize_t          dreq_size,
   output strobe_t         dreq_strobe,
   output word_t           dreq_data,
   input  logic            dresp_data_ok,
   input  word_t           dresp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output word_t           out_data,
   output logic            out_exc
);

   mem_state_t      state_r;
   mem_state_t      next_state_s;
   logic            accept_s;
   logic            capture_s;
   logic            trap_s;
   logic            bus_s;

   instruction_type op_r;
   addr_t           addr_r;
   word_t           wdata_r;
   word_t           result_r;

   addr_t           pre_addr_s;
   msize_t          pre_size_s;
   strobe_t         pre_strobe_s;
   word_t           pre_data_s;
   word_t           post_data_s;

`ifdef MEM_MISALIGN_TRAP_EN
   logic            exc_r;

   mem_misalign_check u_misalign (
      .op   (in_op),
      .addr (in_addr),
      .trap (trap_s)
   );

   // Exception flag follows the op accepted last and clears on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exc_r <= 1'b0;
      end else if (accept_s) begin
         exc_r <= trap_s;
      end
   end

   assign out_exc = exc_r;
`else
   assign trap_s  = 1'b0;
   assign out_exc = 1'b0;
`endif

   databus_pre_align u_pre (
      .op         (op_r),
      .addr       (addr_r),
      .wdata      (wdata_r),
      .req_addr   (pre_addr_s),
      .req_size   (pre_size_s),
      .req_strobe (pre_strobe_s),
      .req_data   (pre_data_s)
   );

   databus_post_align u_post (
      .op     (op_r),
      .offset (addr_r[2:0]),
      .rdata  (dresp_data),
      .result (post_data_s)
   );

   // State register; reset returns to IDLE immediately so a pending request
   // drops without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode with the accept/capture strobes for the datapath.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      capture_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               accept_s = 1'b1;
               if (trap_s) begin
                  next_state_s = HOLD;
               end else if (is_mem_op(in_op)) begin
                  next_state_s = BUS;
               end else begin
                  next_state_s = HOLD;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         BUS: begin
            if (dresp_data_ok) begin
               capture_s    = 1'b1;
               next_state_s = HOLD;
            end else begin
               next_state_s = BUS;
            end
         end
         HOLD: begin
            if (out_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = HOLD;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Operand latch at acceptance; result loads the pass-through value, zero
   // for traps and pending memory ops, or the aligned bus data on data_ok.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r     <= OP_NONE;
         addr_r   <= 64'd0;
         wdata_r  <= 64'd0;
         result_r <= 64'd0;
      end else if (accept_s) begin
         op_r    <= in_op;
         addr_r  <= in_addr;
         wdata_r <= in_wdata;
         if (trap_s) begin
            result_r <= 64'd0;
         end else if (is_mem_op(in_op)) begin
            result_r <= 64'd0;
         end else begin
            result_r <= in_wdata;
         end
      end else if (capture_s) begin
         result_r <= post_data_s;
      end
   end

   assign bus_s       = (state_r == BUS);
   assign in_ready    = (state_r == IDLE);
   assign out_valid   = (state_r == HOLD);
   assign out_data    = result_r;
   assign dreq_valid  = bus_s;
   assign dreq_addr   = bus_s ? pre_addr_s   : 64'd0;
   assign dreq_size   = bus_s ? pre_size_s   : MSIZE1;
   assign dreq_strobe = bus_s ? pre_strobe_s : 8'h00;
   assign dreq_data   = bus_s ? pre_data_s   : 64'd0;

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Directed bench for mem_dbus_stage. Stimulus pushes the expected result into
// a scoreboard queue; a negedge monitor pops and compares on each accepted
// output. Bus-request fields and handshake timing are checked inline.
module tb_mem_dbus_stage;
   import mem_dbus_stage_pkg::*;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   instruction_type in_op;
   addr_t           in_addr;
   word_t           in_wdata;
   logic            dreq_valid;
   addr_t           dreq_addr;
   msize_t          dreq_size;
   strobe_t         dreq_strobe;
   word_t           dreq_data;
   logic            dresp_data_ok;
   word_t           dresp_data;
   logic            out_valid;
   logic            out_ready;
   word_t           out_data;
   logic            out_exc;

   int tests_run = 0;
   int failed    = 0;
   logic [64:0] sb[$];

   mem_dbus_stage dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_op         (in_op),
      .in_addr       (in_addr),
      .in_wdata      (in_wdata),
      .dreq_valid    (dreq_valid),
      .dreq_addr     (dreq_addr),
      .dreq_size     (dreq_size),
      .dreq_strobe   (dreq_strobe),
      .dreq_data     (dreq_data),
      .dresp_data_ok (dresp_data_ok),
      .dresp_data    (dresp_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_exc       (out_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: compare every result handed to writeback.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         tests_run++;
         if (sb.size() == 0) begin
            failed++;
            $display("FAIL unexpected_output: got data 0x%0h exc %0b with nothing expected", out_data, out_exc);
         end else begin
            logic [64:0] e;
            e = sb.pop_front();
            if ({out_exc, out_data} !== e) begin
               failed++;
               $display("FAIL result: got exc %0b data 0x%0h expected exc %0b data 0x%0h",
                        out_exc, out_data, e[64], e[63:0]);
            end
         end
      end
   end

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (!in_ready) begin
         tests_run++;
         failed++;
         $display("FAIL %s ready_timeout: in_ready stuck at 0 expected 1", name);
      end
   endtask

   task automatic do_mem(input string name, input instruction_type op, input addr_t addr,
                         input word_t wdata, input word_t rdata, input int stall,
                         input msize_t esize, input strobe_t estrb, input word_t edata,
                         input word_t eout);
      wait_ready(name);
      sb.push_back({1'b0, eout});
      in_valid = 1'b1;
      in_op    = op;
      in_addr  = addr;
      in_wdata = wdata;
      step();
      in_valid = 1'b0;
      in_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      in_addr  = 64'h0;
      for (int i = 0; i <= stall; i++) begin
         chk({name, " dreq_valid"},  64'(dreq_valid),  64'd1);
         chk({name, " dreq_addr"},   dreq_addr,        addr);
         chk({name, " dreq_size"},   64'(dreq_size),   64'(esize));
         chk({name, " dreq_strobe"}, 64'(dreq_strobe), 64'(estrb));
         chk({name, " dreq_data"},   dreq_data,        edata);
         chk({name, " busy_ready"},  64'(in_ready),    64'd0);
         if (i == stall) begin
            dresp_data_ok = 1'b1;
            dresp_data    = rdata;
         end
         step();
         dresp_data_ok = 1'b0;
         dresp_data    = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      chk({name, " out_valid"},  64'(out_valid),  64'd1);
      chk({name, " req_dropped"}, 64'(dreq_valid), 64'd0);
      step();
      chk({name, " back_idle"},  64'(in_ready),   64'd1);
   endtask

   task automatic do_trap(input string name, input instruction_type op, input addr_t addr);
      wait_ready(name);
      sb.push_back({1'b1, 64'd0});
      in_valid = 1'b1;
      in_op    = op;
      in_addr  = addr;
      in_wdata = 64'h1234;
      step();
      in_valid = 1'b0;
      chk({name, " no_request"}, 64'(dreq_valid), 64'd0);
      chk({name, " out_valid"},  64'(out_valid),  64'd1);
      step();
      chk({name, " back_idle"},  64'(in_ready),   64'd1);
   endtask

   initial begin
      reset         = 1'b1;
      in_valid      = 1'b0;
      in_op         = OP_NONE;
      in_addr       = 64'd0;
      in_wdata      = 64'd0;
      dresp_data_ok = 1'b0;
      dresp_data    = 64'd0;
      out_ready     = 1'b1;
      step();
      step();

      // Reset state
      chk("rst in_ready",    64'(in_ready),    64'd1);
      chk("rst dreq_valid",  64'(dreq_valid),  64'd0);
      chk("rst dreq_addr",   dreq_addr,        64'd0);
      chk("rst dreq_size",   64'(dreq_size),   64'd0);
      chk("rst dreq_strobe", 64'(dreq_strobe), 64'd0);
      chk("rst dreq_data",   dreq_data,        64'd0);
      chk("rst out_valid",   64'(out_valid),   64'd0);
      chk("rst out_data",    out_data,         64'd0);
      chk("rst out_exc",     64'(out_exc),     64'd0);
      reset = 1'b0;
      step();

      // Loads and stores, aligned
      do_mem("ld",  LD,  64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1,
             MSIZE8, 8'h00, 64'd0, 64'h1122_3344_5566_7788);
      do_mem("lb",  LB,  64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1,
             MSIZE1, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FF80);
      do_mem("lbu", LBU, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1,
             MSIZE1, 8'h00, 64'd0, 64'h0000_0000_0000_0080);
      do_mem("lh",  LH,  64'h8000_0002, 64'd0, 64'h0000_0000_BEEF_0000, 0,
             MSIZE2, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF);
      do_mem("lhu", LHU, 64'h8000_0002, 64'd0, 64'h0000_0000_BEEF_0000, 0,
             MSIZE2, 8'h00, 64'd0, 64'h0000_0000_0000_BEEF);
      do_mem("lw_fast", LW, 64'h8000_0004, 64'd0, 64'h7FFF_FFFF_0000_0000, 0,
             MSIZE4, 8'h00, 64'd0, 64'h0000_0000_7FFF_FFFF);
      do_mem("lwu", LWU, 64'h8000_0004, 64'd0, 64'h8000_0001_0000_0000, 2,
             MSIZE4, 8'h00, 64'd0, 64'h0000_0000_8000_0001);
      do_mem("sh",  SH,  64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'h5555_5555_5555_5555, 4,
             MSIZE2, 8'hC0, 64'hABCD_0000_0000_0000, 64'd0);
      do_mem("sb",  SB,  64'h8000_0007, 64'h0000_0000_0000_01FF, 64'd0, 1,
             MSIZE1, 8'h80, 64'hFF00_0000_0000_0000, 64'd0);
      do_mem("sd",  SD,  64'h8000_0010, 64'h0102_0304_0506_0708, 64'd0, 0,
             MSIZE8, 8'hFF, 64'h0102_0304_0506_0708, 64'd0);

      // Misaligned accesses
`ifdef MEM_MISALIGN_TRAP_EN
      do_trap("lw_mis", LW, 64'h8000_0002);
      do_trap("sw_mis", SW, 64'h8000_0002);
      do_trap("sh_mis", SH, 64'h8000_0007);
      do_trap("ld_mis", LD, 64'h8000_0004);
`else
      do_mem("lw_mis", LW, 64'h8000_0002, 64'd0, 64'h0000_8765_4321_0000, 0,
             MSIZE4, 8'h00, 64'd0, 64'hFFFF_FFFF_8765_4321);
      do_mem("sw_mis", SW, 64'h8000_0002, 64'h0000_0000_1122_3344, 64'd0, 1,
             MSIZE4, 8'h3C, 64'h0000_1122_3344_0000, 64'd0);
      do_mem("sh_mis", SH, 64'h8000_0007, 64'h0000_0000_0000_ABCD, 64'd0, 0,
             MSIZE2, 8'h80, 64'hCD00_0000_0000_0000, 64'd0);
`endif

      // Non-memory op with writeback stalled
      wait_ready("alu");
      out_ready = 1'b0;
      sb.push_back({1'b0, 64'd5});
      in_valid = 1'b1;
      in_op    = OP_ALU;
      in_addr  = 64'h8000_0001;
      in_wdata = 64'd5;
      step();
      in_valid = 1'b0;
      chk("alu out_valid_t1", 64'(out_valid),  64'd1);
      chk("alu no_request",   64'(dreq_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("alu hold_valid", 64'(out_valid),  64'd1);
         chk("alu hold_data",  out_data,        64'd5);
         chk("alu hold_noreq", 64'(dreq_valid), 64'd0);
         chk("alu hold_busy",  64'(in_ready),   64'd0);
      end
      out_ready = 1'b1;
      step();
      chk("alu back_idle", 64'(in_ready), 64'd1);

      // Reset pulsed in the middle of a bus request, then a late data_ok
      wait_ready("rst_bus");
      in_valid = 1'b1;
      in_op    = LD;
      in_addr  = 64'h8000_0020;
      in_wdata = 64'd0;
      step();
      in_valid = 1'b0;
      chk("rst_bus dreq_valid", 64'(dreq_valid), 64'd1);
      reset = 1'b1;
      #1;
      chk("rst_bus async_drop", 64'(dreq_valid), 64'd0);
      chk("rst_bus in_ready",   64'(in_ready),   64'd1);
      chk("rst_bus out_valid",  64'(out_valid),  64'd0);
      dresp_data_ok = 1'b1;
      dresp_data    = 64'hCAFE_CAFE_CAFE_CAFE;
      step();
      reset = 1'b0;
      step();
      step();
      dresp_data_ok = 1'b0;
      chk("rst_bus late_ok_valid", 64'(out_valid),  64'd0);
      chk("rst_bus late_ok_data",  out_data,        64'd0);
      chk("rst_bus late_ok_req",   64'(dreq_valid), 64'd0);
      chk("rst_bus late_ok_ready", 64'(in_ready),   64'd1);

      // One more load after reset to prove recovery
      do_mem("ld_after", LD, 64'h8000_0028, 64'd0, 64'h0A0B_0C0D_0E0F_1011, 0,
             MSIZE8, 8'h00, 64'd0, 64'h0A0B_0C0D_0E0F_1011);

      step();
      step();
      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
